// File: rtl/fw_intc_claim_arbiter_if.sv
// Register bus between the hart-side bus fabric and the claim/complete arbiter.
// Every access completes in the cycle it is presented; r_ready is always 1.
interface fw_intc_claim_arbiter_if;
  logic [1:0]  r_adr;
  logic [31:0] r_dat_w;
  logic [31:0] r_dat_r;
  logic        r_we;
  logic        r_valid;
  logic        r_ready;

  modport master (
    output r_adr, r_dat_w, r_we, r_valid,
    input  r_dat_r, r_ready
  );

  modport slave (
    input  r_adr, r_dat_w, r_we, r_valid,
    output r_dat_r, r_ready
  );
endinterface

// File: rtl/fw_intc_claim_arbiter.sv
// Claim/complete interrupt arbiter: samples level sources, picks one eligible
// source round-robin, raises irq and hands its id out through a CLAIM read.
module fw_intc_claim_arbiter #(
  parameter int N_SRCS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  fw_intc_claim_arbiter_if.slave r,
  input  logic [N_SRCS-1:0]     src,
  output logic                  irq
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t            state, state_n;
  logic [N_SRCS-1:0] src_q, enable, in_service, eligible;
  logic [N_SRCS-1:0] set_mask, clr_mask;
  logic [4:0]        claim_id, claim_id_n, rr_ptr, rr_ptr_n, winner;
  logic [31:0]       elig32;
  logic              found, svc_set;
  logic              claim_rd, complete_wr, enable_wr;
  logic              unused_dat;

  assign claim_rd    = r.r_valid & ~r.r_we & (r.r_adr == 2'd1);
  assign complete_wr = r.r_valid &  r.r_we & (r.r_adr == 2'd2) &
                       (r.r_dat_w[4:0] < 5'(N_SRCS));
  assign enable_wr   = r.r_valid &  r.r_we & (r.r_adr == 2'd3);
  assign unused_dat  = ^r.r_dat_w;

  assign eligible = src_q & enable & ~in_service;
  assign elig32   = 32'(eligible);
  assign irq      = (state == PEND);
  assign r.r_ready = 1'b1;

  // Round-robin: scan upward from rr_ptr with wrap; first eligible bit wins.
  always_comb begin
    logic [5:0] idx;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N_SRCS; k++) begin
      idx = {1'b0, rr_ptr} + 6'(k);
      if (idx >= 6'(N_SRCS)) idx = idx - 6'(N_SRCS);
      if (!found && elig32[idx[4:0]]) begin
        found  = 1'b1;
        winner = idx[4:0];
      end
    end
  end

  always_comb begin
    state_n    = state;
    claim_id_n = claim_id;
    rr_ptr_n   = rr_ptr;
    svc_set    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n    = PEND;
          claim_id_n = winner;
        end
      end
      PEND: begin
        if (claim_rd) begin
          svc_set  = 1'b1;
          rr_ptr_n = (claim_id == 5'(N_SRCS - 1)) ? 5'd0 : claim_id + 5'd1;
          state_n  = IDLE;
        end else if (!elig32[claim_id]) begin
          // Source dropped or was disabled before being claimed.
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign set_mask = svc_set     ? N_SRCS'(32'd1 << claim_id)        : '0;
  assign clr_mask = complete_wr ? N_SRCS'(32'd1 << r.r_dat_w[4:0]) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      claim_id   <= '0;
      rr_ptr     <= '0;
      src_q      <= '0;
      enable     <= '0;
      in_service <= '0;
    end else begin
      state      <= state_n;
      claim_id   <= claim_id_n;
      rr_ptr     <= rr_ptr_n;
      src_q      <= src;
      in_service <= (in_service & ~clr_mask) | set_mask;
      if (enable_wr) enable <= r.r_dat_w[N_SRCS-1:0];
    end
  end

  always_comb begin
    r.r_dat_r = '0;
    case (r.r_adr)
      2'd0: r.r_dat_r = 32'(src_q);
      2'd1: if (state == PEND) r.r_dat_r = {1'b1, 26'd0, claim_id};
      2'd2: r.r_dat_r = '0;
      2'd3: r.r_dat_r = 32'(enable);
      default: r.r_dat_r = '0;
    endcase
  end

endmodule

// File: tb/tb_fw_intc_claim_arbiter.sv
// Bench for fw_intc_claim_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a behavioural model.
module tb_fw_intc_claim_arbiter;
  localparam int N = 4;

  logic         clock, reset;
  logic [N-1:0] src;
  logic         irq;
  int           n_chk, n_fail;

  fw_intc_claim_arbiter_if bus();

  fw_intc_claim_arbiter #(.N_SRCS(N)) dut (
    .clock (clock),
    .reset (reset),
    .r     (bus.slave),
    .src   (src),
    .irq   (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  src;
    logic        valid;
    logic        we;
    logic [1:0]  adr;
    logic [31:0] dat;
    logic        exp_irq;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  // behavioural model state
  bit [3:0] m_sq, m_en, m_svc;
  bit       m_pend;
  int       m_cid, m_rr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] s, input logic v, input logic we,
                       input logic [1:0] a, input logic [31:0] d);
    src          = s;
    bus.r_valid  = v;
    bus.r_we     = we;
    bus.r_adr    = a;
    bus.r_dat_w  = d;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 2'd0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    m_sq = '0; m_en = '0; m_svc = '0; m_pend = 0; m_cid = 0; m_rr = 0;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0: return {28'd0, m_sq};
      2'd1: return m_pend ? (32'h8000_0000 | 32'(m_cid)) : 32'h0;
      2'd3: return {28'd0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic [3:0] s, input logic v, input logic we,
                            input logic [1:0] a, input logic [31:0] d);
    bit [3:0] el, svc;
    bit       crd;
    int       win;
    el  = m_sq & m_en & ~m_svc;
    crd = v && !we && a == 2'd1;
    svc = m_svc;
    if (m_pend && crd) svc[m_cid] = 1'b1;
    if (v && we && a == 2'd2 && d[4:0] < 5'(N)) svc[d[1:0]] = 1'b0;
    if (!m_pend) begin
      win = -1;
      for (int i = 0; i < N; i++)
        if (win < 0 && el[(m_rr + i) % N]) win = (m_rr + i) % N;
      if (win >= 0) begin m_pend = 1; m_cid = win; end
    end else if (crd) begin
      m_rr   = (m_cid + 1) % N;
      m_pend = 0;
    end else if (!el[m_cid]) begin
      m_pend = 0;
    end
    m_svc = svc;
    if (v && we && a == 2'd3) m_en = d[3:0];
    m_sq = s;
  endtask

  // Poll for irq at negedges; returns 1 if seen within the budget.
  task automatic wait_irq(input logic [3:0] s, input int budget, output bit seen);
    seen = 0;
    for (int t = 0; t < budget && !seen; t++) begin
      @(negedge clock);
      drive(s, 1'b0, 1'b0, 2'd0, 32'h0);
      #1;
      if (irq === 1'b1) seen = 1;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int exp_ids[5];
    n_chk = 0; n_fail = 0;
    reset = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 2'd3, 32'h0);
    #1;
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_enable", bus.r_dat_r, 32'h0);
    chk("ready_const", 32'(bus.r_ready), 32'h1);

    // ---- directed vector table (src {valid we adr dat} -> irq, r_dat_r) ----
    vecs[0]  = '{4'h0, 1'b1, 1'b1, 2'd3, 32'hF,  1'b0, 32'h0};        // ENABLE=F
    vecs[1]  = '{4'h4, 1'b1, 1'b0, 2'd3, 32'h0,  1'b0, 32'hF};
    vecs[2]  = '{4'h4, 1'b1, 1'b0, 2'd0, 32'h0,  1'b0, 32'h4};
    vecs[3]  = '{4'h4, 1'b1, 1'b0, 2'd1, 32'h0,  1'b1, 32'h8000_0002}; // claim
    vecs[4]  = '{4'h4, 1'b1, 1'b0, 2'd0, 32'h0,  1'b0, 32'h4};
    vecs[5]  = '{4'h4, 1'b1, 1'b0, 2'd1, 32'h0,  1'b0, 32'h0};        // idle claim
    vecs[6]  = '{4'h4, 1'b1, 1'b1, 2'd2, 32'h7,  1'b0, 32'h0};        // complete 7
    vecs[7]  = '{4'h4, 1'b1, 1'b0, 2'd3, 32'h0,  1'b0, 32'hF};
    vecs[8]  = '{4'h4, 1'b1, 1'b1, 2'd2, 32'h2,  1'b0, 32'h0};        // complete 2
    vecs[9]  = '{4'h4, 1'b1, 1'b0, 2'd0, 32'h0,  1'b0, 32'h4};
    vecs[10] = '{4'h4, 1'b0, 1'b0, 2'd0, 32'h0,  1'b1, 32'h4};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      drive(vecs[i].src, vecs[i].valid, vecs[i].we, vecs[i].adr, vecs[i].dat);
      #1;
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      chk($sformatf("vec%0d_rd", i), bus.r_dat_r, vecs[i].exp_rd);
    end

    // ---- round-robin wrap with all sources held ----
    exp_ids = '{0, 1, 2, 3, 0};
    do_reset();
    @(negedge clock);
    drive(4'h0, 1'b1, 1'b1, 2'd3, 32'hF);
    for (int k = 0; k < 5; k++) begin
      wait_irq(4'hF, 8, seen);
      chk($sformatf("rr%0d_irq", k), 32'(seen), 32'h1);
      drive(4'hF, 1'b1, 1'b0, 2'd1, 32'h0);
      #1;
      chk($sformatf("rr%0d_id", k), bus.r_dat_r, 32'h8000_0000 | 32'(exp_ids[k]));
      @(negedge clock);
      drive(4'hF, 1'b1, 1'b1, 2'd2, 32'(exp_ids[k]));
    end

    // ---- source drop while pending ----
    do_reset();
    @(negedge clock);
    drive(4'h0, 1'b1, 1'b1, 2'd3, 32'h8);
    wait_irq(4'h8, 8, seen);
    chk("drop_irq_up", 32'(seen), 32'h1);
    drive(4'h0, 1'b0, 1'b0, 2'd0, 32'h0);
    @(negedge clock); #1;
    chk("drop_irq_hold", 32'(irq), 32'h1);
    @(negedge clock);
    drive(4'h0, 1'b1, 1'b0, 2'd1, 32'h0);
    #1;
    chk("drop_irq_low", 32'(irq), 32'h0);
    chk("drop_claim_rd", bus.r_dat_r, 32'h0);
    @(negedge clock);
    drive(4'h8, 1'b0, 1'b0, 2'd0, 32'h0);
    @(negedge clock); #1;
    chk("drop_rearm_wait", 32'(irq), 32'h0);
    @(negedge clock); #1;
    chk("drop_rearm_irq", 32'(irq), 32'h1);

    // ---- ENABLE=0 blocks everything ----
    do_reset();
    for (int t = 0; t < 8; t++) begin
      @(negedge clock);
      drive(4'hF, 1'b0, 1'b0, 2'd0, 32'h0);
      #1;
      chk("dis_irq", 32'(irq), 32'h0);
    end

    // ---- asynchronous reset while pending ----
    @(negedge clock);
    drive(4'h1, 1'b1, 1'b1, 2'd3, 32'h1);
    wait_irq(4'h1, 8, seen);
    chk("rst_pend_irq", 32'(seen), 32'h1);
    reset = 1'b1;
    drive(4'h1, 1'b1, 1'b0, 2'd3, 32'h0);
    #1;
    chk("rst_async_irq", 32'(irq), 32'h0);
    chk("rst_enable_rd", bus.r_dat_r, 32'h0);

    // ---- random traffic against the model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0]  s;
      logic        v, we;
      logic [1:0]  a;
      logic [31:0] d;
      s  = 4'($urandom_range(0, 15));
      v  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 2'($urandom_range(0, 3));
      d  = (a == 2'd2) ? 32'($urandom_range(0, 7)) : $urandom;
      @(negedge clock);
      drive(s, v, we, a, d);
      #1;
      chk("rnd_irq", 32'(irq), 32'(m_pend));
      chk("rnd_rd", bus.r_dat_r, model_rd(a));
      @(posedge clock);
      model_step(s, v, we, a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
